tmr_pwm_dt: RTL and testbench

Output-compare / PWM stage that sits directly downstream of the n-bit timer. It consumes the timer's `match0_event`, `match1_event` and `ovf_event` outputs and builds a reference waveform from them according to a programmable mode. It then drives a complementary pin pair (`pwm_h` / `pwm_l`) with programmable rising and falling dead time and output polarity. Configuration comes from one SFR (`PWM_CTRL`), which also receives a hardware-set one-shot done flag.

---
 rtl/tmr_pwm_dt_pkg.sv | 21 ++
 rtl/tmr_pwm_dt_deadtime.sv | 82 ++++++++
 rtl/tmr_pwm_dt.sv | 96 +++++++++
 tb/tb_tmr_pwm_dt.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_pwm_dt_pkg.sv
// Shared SFR layout and enums for the PWM / dead-time output stage.
package pkg_sfrs_definition;

  typedef enum logic [1:0] {EDGE, WINDOW, TOGGLE, ONESHOT} pwm_mode_e;

  typedef enum logic [2:0] {OFF, LOW, DT_R, HIGH, DT_F} pwm_dt_state_e;

  typedef struct packed {
    logic [6:0] rsvd_hi;
    logic       done_f;
    logic [7:0] dt_fall;
    logic [7:0] dt_rise;
    logic [3:0] rsvd_lo;
    logic       pol;
    pwm_mode_e  mode;
    logic       en;
  } pwm_ctrl_t;

  localparam int DONE_BIT = 24;

endpackage

// File: rtl/tmr_pwm_dt_deadtime.sv
// Complementary pin driver: inserts rise/fall dead time around the reference level.
module pwm_deadtime
  import pkg_sfrs_definition::*;
#(
  parameter int DT_W = 8
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            ref_lvl,
  input  logic            en,
  input  logic [DT_W-1:0] dt_rise,
  input  logic [DT_W-1:0] dt_fall,
  input  logic            pol,
  output logic            pwm_h,
  output logic            pwm_l
);

  pwm_dt_state_e   state, state_nxt;
  logic [DT_W-1:0] dtc, dtc_nxt;
  logic            h, l;

  always_comb begin
    state_nxt = state;
    dtc_nxt   = dtc;
    h         = 1'b0;
    l         = 1'b0;
    case (state)
      OFF: if (en) state_nxt = LOW;
      LOW: begin
        l = 1'b1;
        if (ref_lvl) begin
          if (dt_rise == '0) state_nxt = HIGH;
          else begin
            state_nxt = DT_R;
            dtc_nxt   = dt_rise;
          end
        end
      end
      // A reference that drops back mid dead-time is absorbed without touching h.
      DT_R: begin
        dtc_nxt = dtc - 1'b1;
        if (!ref_lvl)               state_nxt = LOW;
        else if (dtc == DT_W'(1))   state_nxt = HIGH;
      end
      HIGH: begin
        h = 1'b1;
        if (!ref_lvl) begin
          if (dt_fall == '0) state_nxt = LOW;
          else begin
            state_nxt = DT_F;
            dtc_nxt   = dt_fall;
          end
        end
      end
      DT_F: begin
        dtc_nxt = dtc - 1'b1;
        if (ref_lvl)                state_nxt = HIGH;
        else if (dtc == DT_W'(1))   state_nxt = LOW;
      end
      default: state_nxt = OFF;
    endcase
    if (!en) begin
      state_nxt = OFF;
      dtc_nxt   = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state <= OFF;
      dtc   <= '0;
      pwm_h <= 1'b0;
      pwm_l <= 1'b0;
    end else begin
      state <= state_nxt;
      dtc   <= dtc_nxt;
      pwm_h <= h ^ pol;
      pwm_l <= l ^ pol;
    end
  end

endmodule

// File: rtl/tmr_pwm_dt.sv
// Output-compare stage: timer events -> reference waveform -> dead-time pin pair.
module tmr_pwm_dt
  import pkg_sfrs_definition::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DT_W       = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [DATA_WIDTH-1:0] pwm_ctrl,
  input  logic                  match0_event,
  input  logic                  match1_event,
  input  logic                  ovf_event,
  output logic                  pwm_h,
  output logic                  pwm_l,
  output logic [DATA_WIDTH-1:0] hw_up_pwm_ctrl,
  output logic [DATA_WIDTH-1:0] hw_val_pwm_ctrl
);

  pwm_ctrl_t  ctrl;
  logic [2:0] evt, evt_q, pulse;
  logic       ref_q, ref_nxt, shot_q, shot_nxt, done, done_q;
  logic       set_p, clr_p, tgl_p;
  logic       unused_ctrl;

  assign ctrl        = pwm_ctrl_t'(pwm_ctrl[31:0]);
  assign unused_ctrl = ^{ctrl.rsvd_hi, ctrl.done_f, ctrl.rsvd_lo};

  // {ovf, match1, match0}; events are levels, so only rising edges count
  assign evt   = {ovf_event, match1_event, match0_event};
  assign pulse = evt & ~evt_q;

  always_comb begin
    set_p = 1'b0;
    clr_p = 1'b0;
    tgl_p = 1'b0;
    case (ctrl.mode)
      EDGE:    begin set_p = pulse[2]; clr_p = pulse[0]; end
      TOGGLE:  tgl_p = pulse[0];
      default: begin set_p = pulse[0]; clr_p = pulse[1]; end
    endcase
  end

  always_comb begin
    ref_nxt  = ref_q;
    shot_nxt = shot_q;
    done     = 1'b0;
    if (!ctrl.en) begin
      ref_nxt  = 1'b0;
      shot_nxt = 1'b0;
    end else if (!(ctrl.mode == ONESHOT && shot_q)) begin
      if (clr_p)      ref_nxt = 1'b0;
      else if (set_p) ref_nxt = 1'b1;
      else if (tgl_p) ref_nxt = ~ref_q;
      // Only a real high->low of the window ends the shot.
      if (ctrl.mode == ONESHOT && clr_p && ref_q) begin
        shot_nxt = 1'b1;
        done     = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      evt_q  <= '0;
      ref_q  <= 1'b0;
      shot_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      evt_q  <= evt;
      ref_q  <= ref_nxt;
      shot_q <= shot_nxt;
      done_q <= done;
    end
  end

  always_comb begin
    hw_up_pwm_ctrl            = '0;
    hw_val_pwm_ctrl           = '0;
    hw_up_pwm_ctrl[DONE_BIT]  = done_q;
    hw_val_pwm_ctrl[DONE_BIT] = done_q;
  end

  pwm_deadtime #(.DT_W(DT_W)) u_dt (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .ref_lvl   (ref_q),
    .en        (ctrl.en),
    .dt_rise   (ctrl.dt_rise[DT_W-1:0]),
    .dt_fall   (ctrl.dt_fall[DT_W-1:0]),
    .pol       (ctrl.pol),
    .pwm_h     (pwm_h),
    .pwm_l     (pwm_l)
  );

endmodule

// File: tb/tb_tmr_pwm_dt.sv
// Bench for tmr_pwm_dt: per-cycle reference model, scenario table and corner sequences.
module tb_tmr_pwm_dt;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [31:0] ctrl = '0;
  logic        match0_event = 1'b0, match1_event = 1'b0, ovf_event = 1'b0;
  logic        pwm_h, pwm_l;
  logic [31:0] hw_up_pwm_ctrl, hw_val_pwm_ctrl;

  int checks = 0, failures = 0;

  // model state: edge regs, reference, shot flag, drive side / pending idle cycles
  logic [2:0] m_q;
  logic       m_ref, m_shot, m_on, m_hi;
  int         m_gap;

  // observation counters for directed sequences
  int  cnt_h, cnt_idle, cnt_up, rise_h, first_h, step_idx, overlap;
  logic prev_h = 1'b0;

  always #5 sys_clk = ~sys_clk;

  tmr_pwm_dt dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .pwm_ctrl        (ctrl),
    .match0_event    (match0_event),
    .match1_event    (match1_event),
    .ovf_event       (ovf_event),
    .pwm_h           (pwm_h),
    .pwm_l           (pwm_l),
    .hw_up_pwm_ctrl  (hw_up_pwm_ctrl),
    .hw_val_pwm_ctrl (hw_val_pwm_ctrl)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_ctrl(input int en, input int mode, input int pol,
                                          input int dtr, input int dtf);
    logic [31:0] c;
    c = '0;
    c[0] = en[0]; c[2:1] = mode[1:0]; c[3] = pol[0];
    c[15:8] = dtr[7:0]; c[23:16] = dtf[7:0];
    return c;
  endfunction

  task automatic clear_cnt();
    cnt_h = 0; cnt_idle = 0; cnt_up = 0; rise_h = 0; first_h = 0; step_idx = 0; overlap = 0;
  endtask

  // One clock: advance the model on the inputs seen at this edge, then compare.
  task automatic step();
    logic p, en_i, eh, el, e_up, set, clr, ah, al;
    logic [2:0] ev, pul;
    int md, dtr, dtf;
    en_i = ctrl[0]; md = int'(ctrl[2:1]); p = ctrl[3];
    dtr = int'(ctrl[15:8]); dtf = int'(ctrl[23:16]);
    ev = {ovf_event, match1_event, match0_event};
    e_up = 1'b0;
    if (!sys_rst_n) begin
      m_q = '0; m_ref = 0; m_shot = 0; m_on = 0; m_hi = 0; m_gap = 0;
      eh = 0; el = 0;
    end else begin
      eh = (m_on && m_hi && m_gap == 0) ^ p;
      el = (m_on && !m_hi && m_gap == 0) ^ p;
      if (!en_i) begin m_on = 0; m_hi = 0; m_gap = 0; end
      else if (!m_on) begin m_on = 1; m_hi = 0; m_gap = 0; end
      else if (m_ref != m_hi) begin
        if (m_gap > 0) m_gap = 0;
        else m_gap = m_ref ? dtr : dtf;
        m_hi = m_ref;
      end else if (m_gap > 0) m_gap--;
      pul = ev & ~m_q;
      if (!en_i) begin m_ref = 0; m_shot = 0; end
      else if (!(md == 3 && m_shot)) begin
        if (md == 2) begin
          if (pul[0]) m_ref = !m_ref;
        end else begin
          set = (md == 0) ? pul[2] : pul[0];
          clr = (md == 0) ? pul[0] : pul[1];
          if (clr) begin
            if (md == 3 && m_ref) begin m_shot = 1; e_up = 1; end
            m_ref = 0;
          end else if (set) m_ref = 1;
        end
      end
      m_q = ev;
    end
    @(posedge sys_clk); #1;
    chk("model_pins", longint'({pwm_h, pwm_l}), longint'({eh, el}));
    chk("model_hw_up", longint'(hw_up_pwm_ctrl), longint'(e_up) << 24);
    chk("model_hw_val", longint'(hw_val_pwm_ctrl), longint'(e_up) << 24);
    if (sys_rst_n) begin
      ah = pwm_h ^ p; al = pwm_l ^ p;
      step_idx++;
      if (ah) cnt_h++;
      if (ah && first_h == 0) first_h = step_idx;
      if (!ah && !al) cnt_idle++;
      if (ah && al) overlap++;
      if (ah && !prev_h) rise_h++;
      if (hw_up_pwm_ctrl == 32'h0100_0000 && hw_val_pwm_ctrl == 32'h0100_0000) cnt_up++;
      prev_h = ah;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive_evt(input int sel, input logic v);
    case (sel)
      0: match0_event = v;
      1: match1_event = v;
      default: ovf_event = v;
    endcase
  endtask

  task automatic pulse(input int sel);
    drive_evt(sel, 1'b1); step(); drive_evt(sel, 1'b0);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0; ctrl = '0;
    match0_event = 0; match1_event = 0; ovf_event = 0;
    step();
    chk("reset_pins", longint'({pwm_h, pwm_l}), 0);
    chk("reset_hw", longint'(hw_up_pwm_ctrl | hw_val_pwm_ctrl), 0);
    step();
    sys_rst_n = 1'b1;
  endtask

  typedef struct {
    int mode, dtr, dtf, pol, set_sel, clr_sel, gap;
    int exp_high, exp_idle, exp_lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // mode dtr dtf pol set clr gap | high idle latency(0 = never)
    vecs[0] = '{0, 0, 0, 0, 2, 0, 10, 10, 0, 3};
    vecs[1] = '{1, 3, 5, 0, 0, 1, 20, 17, 8, 6};
    vecs[2] = '{1, 4, 0, 0, 0, 1,  2,  0, 2, 0};
    vecs[3] = '{0, 2, 1, 1, 2, 0,  6,  4, 3, 5};
    vecs[4] = '{2, 1, 2, 0, 0, 0,  8,  7, 3, 4};
    vecs[5] = '{3, 0, 2, 0, 0, 1,  7,  7, 2, 3};
    vecs[6] = '{1, 0, 0, 1, 0, 1,  5,  5, 0, 3};

    for (int v = 0; v < 7; v++) begin
      do_reset();
      ctrl = mk_ctrl(1, vecs[v].mode, vecs[v].pol, vecs[v].dtr, vecs[v].dtf);
      run(4);
      clear_cnt();
      for (int i = 1; i <= vecs[v].gap + 25; i++) begin
        match0_event = 0; match1_event = 0; ovf_event = 0;
        if (i == 1) drive_evt(vecs[v].set_sel, 1'b1);
        if (i == vecs[v].gap + 1) drive_evt(vecs[v].clr_sel, 1'b1);
        step();
      end
      chk($sformatf("vec%0d_high", v), cnt_h, vecs[v].exp_high);
      chk($sformatf("vec%0d_idle", v), cnt_idle, vecs[v].exp_idle);
      chk($sformatf("vec%0d_latency", v), first_h, vecs[v].exp_lat);
      chk($sformatf("vec%0d_overlap", v), overlap, 0);
    end

    // one-shot: second window ignored, done flag once, en toggle re-arms
    do_reset();
    ctrl = mk_ctrl(1, 3, 0, 0, 0);
    run(4);
    clear_cnt();
    pulse(0); run(5); pulse(1); run(6); pulse(0); run(10); pulse(1); run(5);
    chk("oneshot_high", cnt_h, 6);
    chk("oneshot_rises", rise_h, 1);
    chk("oneshot_done_pulses", cnt_up, 1);
    ctrl[0] = 1'b0; run(3);
    ctrl[0] = 1'b1; run(3);
    clear_cnt();
    pulse(0); run(3); pulse(1); run(6);
    chk("oneshot_rearm_high", cnt_h, 4);
    chk("oneshot_rearm_done", cnt_up, 1);

    // simultaneous set and clear in edge mode: clear wins
    do_reset();
    ctrl = mk_ctrl(1, 0, 0, 0, 0);
    run(4);
    clear_cnt();
    ovf_event = 1; match0_event = 1; step();
    ovf_event = 0; match0_event = 0; run(10);
    chk("simul_high", cnt_h, 0);

    // held match0 in toggle mode toggles once
    do_reset();
    ctrl = mk_ctrl(1, 2, 0, 0, 0);
    run(4);
    clear_cnt();
    match0_event = 1; run(4); match0_event = 0; run(10);
    chk("held_toggle_rises", rise_h, 1);
    chk("held_toggle_level", pwm_h, 1);

    // reset while HIGH with inverted polarity, then re-enable
    do_reset();
    ctrl = mk_ctrl(1, 0, 1, 0, 0);
    run(4);
    pulse(2); run(4);
    chk("inv_high_pins", longint'({pwm_h, pwm_l}), 2'b01);
    sys_rst_n = 1'b0; step();
    chk("rst_in_high_pins", longint'({pwm_h, pwm_l}), 2'b00);
    sys_rst_n = 1'b1; step();
    chk("off_inverted_pins", longint'({pwm_h, pwm_l}), 2'b11);
    step();
    chk("low_inverted_pins", longint'({pwm_h, pwm_l}), 2'b10);

    // enable falling: both inactive two cycles later
    do_reset();
    ctrl = mk_ctrl(1, 0, 0, 0, 0);
    run(2);
    chk("en_rise_low", longint'({pwm_h, pwm_l}), 2'b01);
    ctrl[0] = 1'b0; step();
    chk("en_fall_1", longint'({pwm_h, pwm_l}), 2'b01);
    step();
    chk("en_fall_2", longint'({pwm_h, pwm_l}), 2'b00);

    // randomized run against the model, including mid-operation SFR writes
    do_reset();
    for (int c = 0; c < 6000; c++) begin
      if (c % 150 == 0) begin
        ctrl = mk_ctrl(($urandom_range(0, 9) != 0) ? 1 : 0, int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                       int'($urandom_range(0, 6)));
        ctrl[31:24] = 8'($urandom);
        ctrl[7:4]   = 4'($urandom);
      end else if ($urandom_range(0, 40) == 0) begin
        ctrl[15:8]  = 8'($urandom_range(0, 5));
        ctrl[23:16] = 8'($urandom_range(0, 5));
      end
      match0_event = ($urandom_range(0, 5) == 0);
      match1_event = ($urandom_range(0, 5) == 0);
      ovf_event    = ($urandom_range(0, 7) == 0);
      sys_rst_n    = ($urandom_range(0, 999) != 0);
      step();
      if (sys_rst_n) chk("rand_overlap", longint'((pwm_h ^ ctrl[3]) & (pwm_l ^ ctrl[3])), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
